// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int WORD_W          = 16;
    localparam int LATENCY_DEFAULT = 4;

    // Tag encoding used by the cache arbiter to route returning fill words.
    localparam logic [1:0] TAG_ICACHE = 2'b00;
    localparam logic [1:0] TAG_DCACHE = 2'b01;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_pipe_responder_if.sv
// Request/response bus between the cache arbiter (master) and the memory responder (slave).
// Latency: n/a (wiring only).
// Backpressure: none; every enabled request is taken.
interface mem_pipe_responder_if #(
    parameter int ADDR_W = 16,
    parameter int TAG_W  = 2
);
    import mem_pkg::*;

    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    word_t             data_in;
    logic [TAG_W-1:0]  req_tag;
    word_t             data_out;
    logic              data_valid;
    logic [TAG_W-1:0]  rsp_tag;
    logic [3:0]        outstanding;
    logic              idle;

    modport master (
        output enable, wr, addr, data_in, req_tag,
        input  data_out, data_valid, rsp_tag, outstanding, idle
    );

    modport slave (
        input  enable, wr, addr, data_in, req_tag,
        output data_out, data_valid, rsp_tag, outstanding, idle
    );

endinterface

// File: rtl/mem_delay_line.sv
// Fixed-length shift register carrying {valid, tag, data} for in-flight reads.
// Latency: STAGES cycles from in_* to out_*.
// Backpressure: none; shifts every cycle, async reset drops all entries.
module mem_delay_line
    import mem_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int TAG_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    input  word_t            in_dat,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag,
    output word_t            out_dat
);
    localparam int ENT_W = 1 + TAG_W + WORD_W;

    logic [STAGES-1:0][ENT_W-1:0] pipe_q;
    logic [STAGES-1:0][ENT_W-1:0] pipe_d;

    // Stage 0 takes the new entry; every later stage takes its predecessor.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {in_vld, in_tag, in_dat};
        for (int i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Reset clears valid bits along with payload so no stale response survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign {out_vld, out_tag, out_dat} = pipe_q[STAGES-1];

endmodule

// File: rtl/mem_pipe_responder.sv
// Main-memory responder: word array with tagged, fully pipelined read responses.
// Latency: read response LATENCY cycles after the request cycle; writes complete at the sampling edge.
// Backpressure: none; one request accepted every enabled cycle.
module mem_pipe_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 15,
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int TAG_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_pipe_responder_if.slave  bus
);
    logic [DEPTH_W-1:0] idx;
    logic [ADDR_W-1:0]  unused_addr_bits;
    logic               rd_fire;
    word_t              rd_word;

    logic               dl_vld;
    logic [TAG_W-1:0]   dl_tag;
    word_t              dl_dat;

    word_t              mem_q [2**DEPTH_W];

    logic               data_valid_q, data_valid_d;
    word_t              data_out_q,   data_out_d;
    logic [TAG_W-1:0]   rsp_tag_q,    rsp_tag_d;
    logic [3:0]         outstanding_q, outstanding_d;

    // Byte address to word index; bit 0 and any bits above the index are dropped.
    assign idx              = bus.addr[DEPTH_W:1];
    assign unused_addr_bits = bus.addr;
    assign rd_fire          = bus.enable && !bus.wr;

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (bus.enable && bus.wr) begin
            mem_q[idx] <= bus.data_in;
        end
    end

    // Read in the request cycle; a write from the previous edge is already visible.
    assign rd_word = mem_q[idx];

    // LATENCY-1 stages here plus the output register below give LATENCY total.
    mem_delay_line #(
        .STAGES (LATENCY - 1),
        .TAG_W  (TAG_W)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_fire),
        .in_tag  (bus.req_tag),
        .in_dat  (rd_word),
        .out_vld (dl_vld),
        .out_tag (dl_tag),
        .out_dat (dl_dat)
    );

    // Response register: data and tag only move when a response emerges, otherwise hold.
    always_comb begin
        data_valid_d = dl_vld;
        data_out_d   = data_out_q;
        rsp_tag_d    = rsp_tag_q;
        if (dl_vld) begin
            data_out_d = dl_dat;
            rsp_tag_d  = dl_tag;
        end
    end

    // Outstanding reads: up on issue, down on return, unchanged when both coincide.
    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_fire && !data_valid_q) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!rd_fire && data_valid_q) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Control and response state, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_q  <= 1'b0;
            data_out_q    <= '0;
            rsp_tag_q     <= '0;
            outstanding_q <= '0;
        end else begin
            data_valid_q  <= data_valid_d;
            data_out_q    <= data_out_d;
            rsp_tag_q     <= rsp_tag_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.data_valid  = data_valid_q;
    assign bus.data_out    = data_out_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.outstanding = outstanding_q;
    assign bus.idle        = (outstanding_q == 4'd0) && !bus.enable;

endmodule

// File: tb/tb_mem_pipe_responder.sv
// Directed bench for mem_pipe_responder: hand-computed responses checked with immediate assertions.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_pipe_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;

    mem_pipe_responder_if bus ();

    mem_pipe_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: new inputs just after the rising edge, return mid-cycle for checks.
    task automatic drive(input logic en, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] t);
        @(posedge clk);
        #1;
        bus.enable  = en;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        bus.req_tag = t;
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    endtask

    initial begin
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        bus.req_tag = '0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 16'(bus.data_valid), 16'h0000);
        chk("rst_outst", 16'(bus.outstanding), 16'h0000);
        chk("rst_idle",  16'(bus.idle), 16'h0001);
        chk("rst_dout",  bus.data_out, 16'h0000);
        chk("rst_tag",   16'(bus.rsp_tag), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Write then read: read in cycle 1 returns in cycle 5
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, TAG_ICACHE);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000, TAG_DCACHE);
        chk("wr_rd_outst_c1", 16'(bus.outstanding), 16'h0000);
        chk("wr_rd_idle_c1",  16'(bus.idle), 16'h0000);
        for (int c = 2; c <= 4; c++) begin
            idle_cyc();
            chk("wr_rd_early_valid", 16'(bus.data_valid), 16'h0000);
        end
        idle_cyc();
        chk("wr_rd_valid_c5", 16'(bus.data_valid), 16'h0001);
        chk("wr_rd_data_c5",  bus.data_out, 16'hBEEF);
        chk("wr_rd_tag_c5",   16'(bus.rsp_tag), 16'(TAG_DCACHE));
        chk("wr_rd_idle_c5",  16'(bus.idle), 16'h0000);
        idle_cyc();
        chk("wr_rd_valid_c6", 16'(bus.data_valid), 16'h0000);
        chk("wr_rd_hold_c6",  bus.data_out, 16'hBEEF);
        chk("wr_rd_thold_c6", 16'(bus.rsp_tag), 16'(TAG_DCACHE));
        chk("wr_rd_idle_c6",  16'(bus.idle), 16'h0001);

        // Burst fill: preload, four back-to-back reads, in-order responses
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 16'(16'h0020 + 2 * k), 16'(16'hA000 + k), TAG_ICACHE);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 16'(16'h0020 + 2 * k), 16'h0000, TAG_ICACHE);
            chk("burst_outst_issue", 16'(bus.outstanding), 16'(k));
        end
        for (int k = 0; k < 4; k++) begin
            idle_cyc();
            chk("burst_valid", 16'(bus.data_valid), 16'h0001);
            chk("burst_data",  bus.data_out, 16'(16'hA000 + k));
            chk("burst_tag",   16'(bus.rsp_tag), 16'(TAG_ICACHE));
            chk("burst_outst_ret", 16'(bus.outstanding), 16'(4 - k));
        end
        idle_cyc();
        chk("burst_valid_end", 16'(bus.data_valid), 16'h0000);
        chk("burst_outst_end", 16'(bus.outstanding), 16'h0000);
        chk("burst_idle_end",  16'(bus.idle), 16'h0001);

        // Write during flight: in-flight read keeps the old value
        drive(1'b1, 1'b1, 16'h0030, 16'h1111, TAG_ICACHE);
        drive(1'b1, 1'b0, 16'h0030, 16'h0000, TAG_DCACHE);
        drive(1'b1, 1'b1, 16'h0030, 16'h2222, TAG_ICACHE);
        chk("wdf_outst_c1", 16'(bus.outstanding), 16'h0001);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("wdf_valid_c4", 16'(bus.data_valid), 16'h0001);
        chk("wdf_old_data", bus.data_out, 16'h1111);
        idle_cyc();
        drive(1'b1, 1'b0, 16'h0030, 16'h0000, TAG_DCACHE);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("wdf_new_valid", 16'(bus.data_valid), 16'h0001);
        chk("wdf_new_data",  bus.data_out, 16'h2222);
        idle_cyc();

        // Reset mid-flight: in-flight reads vanish, array contents survive
        drive(1'b1, 1'b1, 16'h0040, 16'h4444, TAG_ICACHE);
        drive(1'b1, 1'b0, 16'h0040, 16'h0000, TAG_ICACHE);
        drive(1'b1, 1'b0, 16'h0040, 16'h0000, TAG_DCACHE);
        idle_cyc();
        chk("rmf_outst_pre", 16'(bus.outstanding), 16'h0002);
        rst = 1'b1;
        #1;
        chk("rmf_outst_now", 16'(bus.outstanding), 16'h0000);
        chk("rmf_valid_now", 16'(bus.data_valid), 16'h0000);
        chk("rmf_dout_now",  bus.data_out, 16'h0000);
        chk("rmf_tag_now",   16'(bus.rsp_tag), 16'h0000);
        chk("rmf_idle_now",  16'(bus.idle), 16'h0001);
        for (int c = 3; c <= 8; c++) begin
            idle_cyc();
            chk("rmf_valid_quiet", 16'(bus.data_valid), 16'h0000);
            chk("rmf_outst_quiet", 16'(bus.outstanding), 16'h0000);
            if (c == 3) rst = 1'b0;
        end
        drive(1'b1, 1'b0, 16'h0040, 16'h0000, TAG_DCACHE);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("rmf_keep_valid", 16'(bus.data_valid), 16'h0001);
        chk("rmf_keep_data",  bus.data_out, 16'h4444);
        idle_cyc();

        // Odd byte address selects the same word as the even one
        drive(1'b1, 1'b1, 16'h0001, 16'h5A5A, TAG_ICACHE);
        drive(1'b1, 1'b0, 16'h0000, 16'h0000, TAG_ICACHE);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("odd_valid", 16'(bus.data_valid), 16'h0001);
        chk("odd_data",  bus.data_out, 16'h5A5A);
        idle_cyc();

        // Continuous reads for 10 cycles: counter holds at 4 while issue and return overlap
        for (int c = 0; c < 15; c++) begin
            if (c < 10) begin
                drive(1'b1, 1'b0, 16'(16'h0020 + 2 * (c % 4)), 16'h0000, 2'(c % 2));
            end else begin
                idle_cyc();
            end
            chk("cont_idle", 16'(bus.idle), (c >= 14) ? 16'h0001 : 16'h0000);
            chk("cont_outst", 16'(bus.outstanding),
                (c <= 4) ? 16'(c) : ((c <= 10) ? 16'h0004 : 16'(14 - c)));
            if (c >= 4 && c <= 13) begin
                chk("cont_valid", 16'(bus.data_valid), 16'h0001);
                chk("cont_data",  bus.data_out, 16'(16'hA000 + ((c - 4) % 4)));
                chk("cont_tag",   16'(bus.rsp_tag), 16'((c - 4) % 2));
            end else begin
                chk("cont_valid_off", 16'(bus.data_valid), 16'h0000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
